// File: rtl/lzrw1_decompressor_stream.sv
// LZRW1 decompressor: expands literal/copy items into a byte stream via a circular history buffer.
// Latency: literal byte valid one edge after accept; copy bytes follow one per free-slot edge starting one edge after accept.
// Backpressure: single output register; a stalled sink freezes the copy engine and holds in_ready low.
module lzrw1_decompressor_stream #(
  parameter int HIST_DEPTH = 4096,
  parameter int OFFSET_W   = 12,
  parameter int LEN_W      = 4,
  parameter int CNT_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [15:0]       data_in,
  input  logic              control_word_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              range_error,
  output logic [CNT_W-1:0]  bytes_out
);

  typedef enum logic {IDLE, COPY} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [OFFSET_W-1:0] wr_ptr;
  logic [OFFSET_W-1:0] rd_ptr;
  logic [OFFSET_W-1:0] fill;
  logic [LEN_W:0]      remaining;
  logic                err_copy;   // current copy is out of range: emit zeros
  logic [7:0]          hist [HIST_DEPTH];

  logic                slot_free;
  logic                lit_acc;
  logic                cpy_acc;
  logic                cpy_step;
  logic                hist_we;
  logic [7:0]          hist_wdat;
  logic [7:0]          cpy_byte;
  logic [OFFSET_W-1:0] cpy_off;
  logic [LEN_W:0]      cpy_len;
  logic                cpy_bad;

  assign slot_free = !out_valid || out_ready;
  // Held low during reset so nothing can be offered into a block in reset.
  assign in_ready  = (state == IDLE) && slot_free && !clear && !reset;
  assign busy      = (state == COPY) || out_valid;

  assign cpy_off   = data_in[OFFSET_W-1:0];
  assign cpy_len   = {1'b0, data_in[15:OFFSET_W]} + (LEN_W+1)'(1);
  assign cpy_bad   = (cpy_off == '0) || (cpy_off > fill);

  // History read is asynchronous, so the byte written on the previous edge is
  // already visible: overlapping copies (offset 1 etc.) need no bypass path.
  assign cpy_byte  = err_copy ? 8'h00 : hist[rd_ptr];
  assign hist_we   = lit_acc || cpy_step;
  assign hist_wdat = lit_acc ? data_in[7:0] : cpy_byte;

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and per-edge action strobes; clear overrides everything.
  always_comb begin
    state_nxt = state;
    lit_acc   = 1'b0;
    cpy_acc   = 1'b0;
    cpy_step  = 1'b0;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (control_word_in) begin
              cpy_acc   = 1'b1;
              state_nxt = COPY;
            end else begin
              lit_acc = 1'b1;
            end
          end
        end
        COPY: begin
          if (slot_free) begin
            cpy_step = 1'b1;
            if (remaining == (LEN_W+1)'(1)) state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // History RAM write port; contents are intentionally not reset.
  always_ff @(posedge clock) begin
    if (hist_we) hist[wr_ptr] <= hist_wdat;
  end

  // Output register, pointers, fill level, error flag and byte counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_byte    <= 8'h00;
      out_valid   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      remaining   <= '0;
      err_copy    <= 1'b0;
      range_error <= 1'b0;
      bytes_out   <= '0;
    end else if (clear) begin
      out_valid   <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fill        <= '0;
      remaining   <= '0;
      err_copy    <= 1'b0;
      range_error <= 1'b0;
      bytes_out   <= '0;
    end else begin
      if (out_valid && out_ready) bytes_out <= bytes_out + CNT_W'(1);

      if (lit_acc || cpy_step) begin
        out_byte  <= hist_wdat;
        out_valid <= 1'b1;
        wr_ptr    <= wr_ptr + OFFSET_W'(1);
        if (fill != '1) fill <= fill + OFFSET_W'(1);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (cpy_step) begin
        rd_ptr    <= rd_ptr + OFFSET_W'(1);
        remaining <= remaining - (LEN_W+1)'(1);
      end

      if (cpy_acc) begin
        rd_ptr    <= wr_ptr - cpy_off;
        remaining <= cpy_len;
        err_copy  <= cpy_bad;
        if (cpy_bad) range_error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lzrw1_decompressor_stream.sv
// Directed bench for lzrw1_decompressor_stream: literals, copies, overlap, range error,
// stalls, pointer wrap, clear and mid-copy reset, checked against hand-computed streams.
module tb_lzrw1_decompressor_stream;

  logic        clock;
  logic        reset;
  logic        clear;
  logic [15:0] data_in;
  logic        control_word_in;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        range_error;
  logic [31:0] bytes_out;

  int checks;
  int failures;
  int lowcnt;

  logic [7:0] got[$];
  time        tq[$];
  logic [7:0] exp_q[$];
  logic [7:0] model[$];

  lzrw1_decompressor_stream dut (
    .clock(clock), .reset(reset), .clear(clear), .data_in(data_in),
    .control_word_in(control_word_in), .in_valid(in_valid), .in_ready(in_ready),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .range_error(range_error), .bytes_out(bytes_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Capture every output handshake mid-cycle (inputs only change just after posedge).
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      got.push_back(out_byte);
      tq.push_back($time);
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // Present one item and hold it until accepted; called at posedge+1.
  task automatic send_item(input logic c, input logic [15:0] d);
    int  n;
    logic acc;
    control_word_in = c;
    data_in  = d;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'(1));
  endtask

  // Wait until the block is idle, counting cycles with in_ready low.
  task automatic drain();
    int n;
    n = 0;
    while (n < 200) begin
      @(negedge clock);
      if (!in_ready) lowcnt++;
      if (!busy) break;
      n++;
    end
    if (busy) chk("drain_timeout", 32'(busy), 32'(0));
    @(posedge clock);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    got.delete();
    tq.delete();
    exp_q.delete();
    model.delete();
  endtask

  task automatic cmp_stream(input string tag);
    int bad;
    bad = 0;
    chk({tag, "_len"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (got[i] !== exp_q[i]) bad++;
    chk({tag, "_bytes"}, 32'(bad), 32'(0));
  endtask

  // Literal with model update.
  task automatic lit_m(input logic [7:0] b);
    send_item(1'b0, {8'h00, b});
    model.push_back(b);
  endtask

  // Copy with model update (valid offsets only).
  task automatic copy_m(input int off, input int len);
    logic [7:0] b;
    send_item(1'b1, 16'((((len - 1) & 15) << 12) | off));
    for (int k = 0; k < len; k++) begin
      b = model[model.size() - off];
      model.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  initial begin
    time t0;
    int  holdbad;
    int  stallbad;
    logic prev_stall;
    logic [7:0] prev_byte;
    logic [3:0] pat;

    checks = 0; failures = 0; lowcnt = 0;
    reset = 1'b1; clear = 1'b0; data_in = '0; control_word_in = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset values.
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_byte", 32'(out_byte), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_range_error", 32'(range_error), 32'(0));
    chk("rst_bytes_out", bytes_out, 32'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", 32'(in_ready), 32'(1));
    @(posedge clock); #1;

    // Back-to-back literals.
    t0 = $time;
    send_item(1'b0, 16'h0061);
    send_item(1'b0, 16'h0062);
    send_item(1'b0, 16'h0063);
    chk("lit_accept_cycles", 32'(($time - t0) / 10), 32'(3));
    drain();
    exp_q = '{8'h61, 8'h62, 8'h63};
    cmp_stream("lit_abc");
    if (tq.size() == 3) begin
      chk("lit_gap01", 32'(tq[1] - tq[0]), 32'(10));
      chk("lit_gap12", 32'(tq[2] - tq[1]), 32'(10));
    end else chk("lit_tq_size", 32'(tq.size()), 32'(3));
    chk("lit_bytes_out", bytes_out, 32'(3));

    // Copy offset 3 length 6.
    do_clear();
    chk("clr_bytes_out", bytes_out, 32'(0));
    send_item(1'b0, 16'h0061);
    send_item(1'b0, 16'h0062);
    send_item(1'b0, 16'h0063);
    send_item(1'b1, 16'h5003);
    lowcnt = 0;
    drain();
    chk("copy_in_ready_low", 32'(lowcnt), 32'(6));
    exp_q = '{8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63, 8'h61, 8'h62, 8'h63};
    cmp_stream("copy_abc");
    chk("copy_range_error", 32'(range_error), 32'(0));
    chk("copy_bytes_out", bytes_out, 32'(9));

    // Overlapping copy offset 1 length 16.
    do_clear();
    send_item(1'b0, 16'h0078);
    send_item(1'b1, 16'hF001);
    drain();
    for (int i = 0; i < 17; i++) exp_q.push_back(8'h78);
    cmp_stream("ovl");
    chk("ovl_bytes_out", bytes_out, 32'(17));

    // Range error: offset 5 with only 2 bytes written.
    do_clear();
    send_item(1'b0, 16'h0011);
    send_item(1'b0, 16'h0022);
    send_item(1'b1, 16'h2005);
    drain();
    exp_q = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
    cmp_stream("rerr");
    chk("rerr_flag", 32'(range_error), 32'(1));
    do_clear();
    chk("rerr_cleared", 32'(range_error), 32'(0));

    // clear together with a valid item: item must be dropped.
    data_in = 16'h0099; control_word_in = 1'b0; in_valid = 1'b1; clear = 1'b1;
    @(negedge clock);
    chk("clr_vld_in_ready", 32'(in_ready), 32'(0));
    @(posedge clock); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clock);
    chk("clr_vld_out_valid", 32'(out_valid), 32'(0));
    @(posedge clock); #1;

    // Copy with a stalling sink.
    do_clear();
    send_item(1'b0, 16'h0001);
    send_item(1'b0, 16'h0002);
    send_item(1'b0, 16'h0003);
    send_item(1'b0, 16'h0004);
    send_item(1'b1, 16'h3004);
    pat = 4'b1001;  // out_ready sequence 1,0,0,1 (bit 3 first)
    holdbad = 0; stallbad = 0; prev_stall = 1'b0; prev_byte = 8'h00;
    for (int i = 0; i < 24; i++) begin
      out_ready = pat[3 - (i % 4)];
      @(negedge clock);
      if (prev_stall && (!out_valid || out_byte !== prev_byte)) holdbad++;
      if (out_valid && !out_ready && in_ready) stallbad++;
      prev_stall = out_valid && !out_ready;
      prev_byte  = out_byte;
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    drain();
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04};
    cmp_stream("stall");
    chk("stall_hold", 32'(holdbad), 32'(0));
    chk("stall_in_ready", 32'(stallbad), 32'(0));
    chk("stall_bytes_out", bytes_out, 32'(8));

    // Pointer wrap: 4100 literals then far and wrapping copies.
    do_clear();
    t0 = $time;
    for (int i = 0; i < 4100; i++) lit_m(8'((i * 7 + 3) & 255));
    chk("wrap_lit_cycles", 32'(($time - t0) / 10), 32'(4100));
    drain();
    got.delete(); tq.delete(); exp_q.delete();
    copy_m(4095, 2);
    copy_m(10, 16);
    drain();
    chk("wrap_far_byte0", 32'(exp_q[0]), 32'(8'h26));
    cmp_stream("wrap");
    chk("wrap_range_error", 32'(range_error), 32'(0));

    // Reset in the middle of a copy.
    do_clear();
    send_item(1'b0, 16'h0041);
    send_item(1'b1, 16'hF001);
    @(posedge clock); #1;
    @(posedge clock); #1;
    #2 reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_in_ready", 32'(in_ready), 32'(0));
    @(posedge clock); #1;
    reset = 1'b0;
    got.delete(); tq.delete();
    send_item(1'b0, 16'h005A);
    drain();
    exp_q = '{8'h5A};
    cmp_stream("midrst_lit");
    chk("midrst_bytes_out", bytes_out, 32'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
